// File: rtl/morse_tx.sv
// Serial Morse symbol transmitter: shifts a pattern out LSB first, one bit per
// TICK_DIV clocks, then GAP_BITS silent bit-periods. Optional MORSE_TX_REPEAT_EN adds auto-repeat.
module morse_tx #(
   parameter int PATTERN_W = 12,
   parameter int LEN_W     = 4,
   parameter int TICK_DIV  = 25000000,
   parameter int GAP_BITS  = 3
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [PATTERN_W-1:0] pattern,
   input  logic [LEN_W-1:0]     length,
   input  logic                 abort,
`ifdef MORSE_TX_REPEAT_EN
   // 'repeat' is a reserved word, hence the prefix
   input  logic                 i_repeat,
`endif
   output logic                 ready,
   output logic                 busy,
   output logic                 led_out,
   output logic                 done
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int GAP_W  = $clog2(GAP_BITS + 1);
   localparam int CNT_W  = (GAP_W > LEN_W) ? GAP_W : LEN_W;

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

   state_t               r_state, w_state_next;
   logic [PATTERN_W-1:0] r_shift, w_shift_next, w_shifted;
   logic [CNT_W-1:0]     r_remain, w_remain_next;
   logic [TICK_W-1:0]    r_tick, w_tick_next;
   logic                 r_led, w_led_next;
   logic                 r_done, w_done_next;
   logic                 r_ready, r_busy;
   logic                 w_tick_wrap, w_accept, w_pattern_end;
   logic [LEN_W-1:0]     w_len_clamped;

   assign w_tick_wrap   = (r_tick == TICK_W'(TICK_DIV - 1));
   assign w_accept      = (r_state == S_IDLE) && start && (length != '0);
   assign w_len_clamped = (length > LEN_W'(PATTERN_W)) ? LEN_W'(PATTERN_W) : length;
   assign w_shifted     = r_shift >> 1;

`ifdef MORSE_TX_REPEAT_EN
   logic [PATTERN_W-1:0] r_pat_cap;
   logic [LEN_W-1:0]     r_len_cap;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pat_cap <= '0;
         r_len_cap <= '0;
      end else if (w_accept) begin
         r_pat_cap <= pattern;
         r_len_cap <= w_len_clamped;
      end
   end
`endif

   // NOTE: every next-value signal gets a default first so no latch is inferred.
   always_comb begin
      w_state_next  = r_state;
      w_shift_next  = r_shift;
      w_remain_next = r_remain;
      w_tick_next   = r_tick;
      w_led_next    = r_led;
      w_done_next   = 1'b0;
      w_pattern_end = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_tick_next = '0;
            w_led_next  = 1'b0;
            if (w_accept) begin
               w_state_next  = S_SEND;
               w_shift_next  = pattern;
               w_remain_next = CNT_W'(w_len_clamped);
               w_led_next    = pattern[0];
            end
         end
         S_SEND: begin
            w_tick_next = w_tick_wrap ? '0 : r_tick + 1'b1;
            if (w_tick_wrap) begin
               w_shift_next  = w_shifted;
               w_remain_next = r_remain - 1'b1;
               w_led_next    = w_shifted[0];
               if (r_remain == CNT_W'(1)) begin
                  if (GAP_BITS == 0) begin
                     w_pattern_end = 1'b1;
                  end else begin
                     w_state_next  = S_GAP;
                     w_remain_next = CNT_W'(GAP_BITS);
                     w_led_next    = 1'b0;
                  end
               end
            end
         end
         S_GAP: begin
            w_tick_next = w_tick_wrap ? '0 : r_tick + 1'b1;
            w_led_next  = 1'b0;
            if (w_tick_wrap) begin
               w_remain_next = r_remain - 1'b1;
               if (r_remain == CNT_W'(1)) w_pattern_end = 1'b1;
            end
         end
         default: w_state_next = S_IDLE;
      endcase

      if (w_pattern_end) begin
         w_done_next  = 1'b1;
         w_state_next = S_IDLE;
         w_led_next   = 1'b0;
         w_tick_next  = '0;
`ifdef MORSE_TX_REPEAT_EN
         if (i_repeat) begin
            w_state_next  = S_SEND;
            w_shift_next  = r_pat_cap;
            w_remain_next = CNT_W'(r_len_cap);
            w_led_next    = r_pat_cap[0];
         end
`endif
      end

      // Abort outranks a coinciding tick wrap or pattern end.
      if (abort && (r_state != S_IDLE)) begin
         w_state_next = S_IDLE;
         w_led_next   = 1'b0;
         w_done_next  = 1'b0;
         w_tick_next  = '0;
      end
   end

   // NOTE: clocked state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_shift  <= '0;
         r_remain <= '0;
         r_tick   <= '0;
         r_led    <= 1'b0;
         r_done   <= 1'b0;
         r_ready  <= 1'b1;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_shift  <= w_shift_next;
         r_remain <= w_remain_next;
         r_tick   <= w_tick_next;
         r_led    <= w_led_next;
         r_done   <= w_done_next;
         r_ready  <= (w_state_next == S_IDLE);
         r_busy   <= (w_state_next != S_IDLE);
      end
   end

   assign ready   = r_ready;
   assign busy    = r_busy;
   assign led_out = r_led;
   assign done    = r_done;

endmodule

// File: tb/tb_morse_tx.sv
// Directed self-checking bench for morse_tx with TICK_DIV=4, GAP_BITS=3, PATTERN_W=12.
module tb_morse_tx;

   localparam int PATTERN_W = 12;
   localparam int LEN_W     = 4;
   localparam int TICK_DIV  = 4;
   localparam int GAP_BITS  = 3;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic                 start;
   logic [PATTERN_W-1:0] pattern;
   logic [LEN_W-1:0]     length;
   logic                 abort;
   logic                 ready, busy, led_out, done;
`ifdef MORSE_TX_REPEAT_EN
   logic                 r_repeat;
`endif

   int n_checks = 0;
   int n_errors = 0;

   morse_tx #(
      .PATTERN_W(PATTERN_W), .LEN_W(LEN_W), .TICK_DIV(TICK_DIV), .GAP_BITS(GAP_BITS)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .pattern(pattern),
      .length(length), .abort(abort),
`ifdef MORSE_TX_REPEAT_EN
      .i_repeat(r_repeat),
`endif
      .ready(ready), .busy(busy), .led_out(led_out), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      check({tag, " ready"}, ready, 1'b1);
      check({tag, " busy"}, busy, 1'b0);
      check({tag, " led"}, led_out, 1'b0);
      check({tag, " done"}, done, 1'b0);
   endtask

   // Starts a transfer from the current negedge and checks every cycle N+1..done.
   // Inputs are scrambled while busy; abort_at>0 aborts after that cycle instead.
   task automatic send(input logic [PATTERN_W-1:0] pat, input logic [LEN_W-1:0] len,
                       input int eff, input string tag, input int abort_at, input bit hold);
      int last;
      logic [PATTERN_W-1:0] p;
      logic exp_led;
      last = 1 + (eff + GAP_BITS) * TICK_DIV;
      p = pat;
      pattern = pat;
      length  = len;
      start   = 1'b1;
      step();
      abort = 1'b0;
      if (!hold) start = 1'b0;
      pattern = ~pat;
      length  = 4'd2;
      for (int k = 1; k <= last; k++) begin
         exp_led = (k <= eff * TICK_DIV) ? p[(k - 1) / TICK_DIV] : 1'b0;
         check($sformatf("%s led k=%0d", tag, k), led_out, exp_led);
         check($sformatf("%s done k=%0d", tag, k), done, k == last);
         check($sformatf("%s ready k=%0d", tag, k), ready, k == last);
         check($sformatf("%s busy k=%0d", tag, k), busy, k != last);
         if (k == abort_at) begin
            abort = 1'b1;
            step();
            abort = 1'b0;
            check_idle($sformatf("%s aborted", tag));
            return;
         end
         if (k < last) step();
      end
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      pattern = '0;
      length  = '0;
      abort   = 1'b0;
`ifdef MORSE_TX_REPEAT_EN
      r_repeat = 1'b0;
`endif
      step();
      check_idle("reset");
      reset_n = 1'b1;
      step();
      check_idle("post_reset");

      send(12'b000000011101, 4'd5, 5, "basic", 0, 1'b0);
      // started in the previous done cycle: back-to-back, clamped to 12 bits
      send(12'hFFF, 4'd15, 12, "clamp", 0, 1'b0);

      step();
      pattern = 12'h005;
      length  = 4'd0;
      start   = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         check_idle($sformatf("len0 k=%0d", k));
      end
      start = 1'b0;

      send(12'h9A5, 4'd8, 8, "alt", 0, 1'b0);

      send(12'b000000011101, 4'd5, 5, "abort", 10, 1'b0);
      step();
      check_idle("abort_n12");
      abort = 1'b1;
      send(12'b000000011101, 4'd5, 5, "after_abort", 0, 1'b0);

      send(12'h001, 4'd1, 1, "hold_a", 0, 1'b1);
      send(12'h001, 4'd1, 1, "hold_b", 0, 1'b0);

      step();
      pattern = 12'b000000011101;
      length  = 4'd5;
      start   = 1'b1;
      step();
      start = 1'b0;
      for (int k = 2; k <= 7; k++) step();
      check("rst_mid busy", busy, 1'b1);
      reset_n = 1'b0;
      #1;
      check_idle("rst_async");
      step();
      step();
      reset_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         step();
         check($sformatf("rst_nodone k=%0d", k), done, 1'b0);
      end
      check_idle("rst_after");

      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      send(12'h001, 4'd1, 1, "first_start", 0, 1'b0);

`ifdef MORSE_TX_REPEAT_EN
      step();
      r_repeat = 1'b1;
      pattern  = 12'h001;
      length   = 4'd1;
      start    = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 49; k++) begin
         check($sformatf("rep done k=%0d", k), done, (k > 1) && ((k % 16) == 1));
         check($sformatf("rep ready k=%0d", k), ready, 1'b0);
         step();
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      r_repeat = 1'b0;
      check_idle("rep_abort");
      step();
      check_idle("rep_stopped");
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/morse_tx.md
MORSE_TX -- requirements
Module: morse_tx

Interface
REQ-001 Parameter PATTERN_W, default 12, sets the maximum symbol pattern length in bits.
REQ-002 Parameter LEN_W, default 4, sets the length field width and SHALL satisfy 2**LEN_W > PATTERN_W.
REQ-003 Parameter TICK_DIV, default 25000000, sets clk cycles per output bit (0.5 s at 50 MHz), with a minimum of 1.
REQ-004 Parameter GAP_BITS, default 3, sets trailing zero bit-periods after each pattern, with a minimum of 0.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port start, input, 1 bit: request to transmit, accepted only when ready=1.
REQ-008 Port pattern, input, PATTERN_W bits: symbol bits, transmitted LSB first.
REQ-009 Port length, input, LEN_W bits: number of pattern bits to send.
REQ-010 Port abort, input, 1 bit: synchronous cancel of the transmission in progress.
REQ-011 Port ready, output, 1 bit: the block is in IDLE and able to accept start.
REQ-012 Port busy, output, 1 bit: equal to not ready.
REQ-013 Port led_out, output, 1 bit: serial Morse drive, 1 = LED on.
REQ-014 Port done, output, 1 bit: single-cycle pulse at the end of each pattern-plus-gap.

Function
REQ-015 The controller SHALL be a state machine with three states, IDLE, SEND and GAP, and all outputs SHALL be registered.
REQ-016 In IDLE: ready=1, led_out=0, and the tick counter is held at 0.
REQ-017 When start=1 and ready=1 at edge N with a non-zero length, the block SHALL capture pattern into the shift register and min(length, PATTERN_W) into the remaining-bit counter, then enter SEND.
REQ-018 start with length=0 SHALL be ignored: the block stays in IDLE and asserts no done.
REQ-019 Any length greater than PATTERN_W SHALL be clamped to PATTERN_W.
REQ-020 In SEND, led_out SHALL equal shift_reg[0], starting from cycle N+1.
REQ-021 Each bit SHALL be held for exactly TICK_DIV cycles; the tick counter counts 0 to TICK_DIV-1 and wraps.
REQ-022 At tick wrap in SEND, the block SHALL shift right (zero fill) and decrement the remaining-bit counter.
REQ-023 At tick wrap with remaining=1, the block SHALL enter GAP, or go directly to pattern end if GAP_BITS=0.
REQ-024 In GAP, led_out=0 for GAP_BITS*TICK_DIV cycles.
REQ-025 At pattern end, done=1 for one cycle and the block SHALL be in IDLE in that same cycle, i.e. cycle N+1+(len+GAP_BITS)*TICK_DIV.
REQ-026 start during the done cycle SHALL be accepted, giving back-to-back transmissions with no idle bit.
REQ-027 start while busy=1 SHALL be ignored, and pattern/length changes while busy SHALL have no effect.
REQ-028 abort=1 in SEND or GAP SHALL force IDLE on the next edge with led_out=0 and no done pulse.
REQ-029 abort has priority over a simultaneous tick wrap; abort in IDLE has no effect.
REQ-030 When abort and start are both high in IDLE, start SHALL be accepted.

Reset
REQ-031 reset_n=0 SHALL asynchronously force IDLE, the shift register to 0, the counters to 0, led_out=0, done=0, ready=1 and busy=0.
REQ-032 Reset asserted mid-transmission SHALL discard the pattern, and no done SHALL follow the release of reset.
REQ-033 The first start SHALL be honoured on the first rising edge after reset_n returns high.

Configuration
REQ-034 Macro MORSE_TX_REPEAT_EN, when defined, SHALL add a 1-bit input port repeat.
REQ-035 With MORSE_TX_REPEAT_EN defined and repeat=1 at pattern end, the block SHALL pulse done, reload the captured pattern and length, and re-enter SEND with ready held at 0.
REQ-036 With MORSE_TX_REPEAT_EN defined, abort SHALL stop repetition as in REQ-028.
REQ-037 Without MORSE_TX_REPEAT_EN, the repeat port SHALL be absent and the block SHALL always return to IDLE at pattern end.

Verification (TICK_DIV=4, GAP_BITS=3, PATTERN_W=12)
REQ-038 pattern=12'b000000011101, length=5, start at N -> led_out 1,0,1,1,1 each for 4 cycles from N+1, then 0 for 12 cycles, done at N+33 only.
REQ-039 length=15 with pattern=12'hFFF -> led_out=1 for 48 cycles (clamped to 12 bits), then a 12-cycle gap, done at N+61.
REQ-040 length=0 with start -> ready stays 1, led_out stays 0, and no done pulse.
REQ-041 abort at N+10 of the REQ-038 transfer -> IDLE and led_out=0 at N+11, no done; start at N+12 is accepted.
REQ-042 reset_n pulled low at N+7 mid-send -> outputs reach reset values immediately; no done within 40 cycles after release.
REQ-043 start held high through done (pattern=12'b1, length=1) -> a second transfer starts on the done cycle with no idle bit; with MORSE_TX_REPEAT_EN and repeat=1, done every 16 cycles and ready=0 throughout.
